boreal_feature_normalizer: RTL and testbench

Z-score normalization stage directly upstream of the 2x8 spatial filter. It takes 8 raw signed 16-bit feature channels (band powers) per sample and subtracts a per-channel mean. It scales each result by a runtime-loaded per-channel inverse standard deviation, saturates, and emits the packed 128-bit z-score vector the spatial filter consumes. Channels are processed serially, one per cycle, to share a single multiplier.

---
 rtl/boreal_feature_normalizer_if.sv | 23 ++
 rtl/boreal_feature_normalizer.sv | 160 ++++++++++++++++
 tb/tb_boreal_feature_normalizer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/boreal_feature_normalizer_if.sv
// Sample, result and register-write signals of the z-score normalizer.
// The master drives samples and register writes; the slave is the normalizer.
interface boreal_feature_normalizer_if;
    logic         valid;
    logic [127:0] raw;
    logic         in_ready;
    logic [127:0] features;
    logic         out_valid;
    logic         drop;
    logic [3:0]   reg_addr;
    logic [15:0]  reg_din;
    logic         reg_we;

    modport master (
        output valid, raw, reg_addr, reg_din, reg_we,
        input  in_ready, features, out_valid, drop
    );

    modport slave (
        input  valid, raw, reg_addr, reg_din, reg_we,
        output in_ready, features, out_valid, drop
    );
endinterface

// File: rtl/boreal_feature_normalizer.sv
// Serial 8-channel z-score normalizer: one shared multiplier, one channel per cycle.
// Define BOREAL_NORM_ADAPT_EN to track per-channel means with an EMA.
module boreal_feature_normalizer #(
    parameter int ALPHA_SHIFT = 6
) (
    input logic                          clk,
    input logic                          rst,
    boreal_feature_normalizer_if.slave   bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_r;
    logic [2:0]          ch_r;
    logic [127:0]        raw_r;
    logic [127:0]        stage_r;
    logic [127:0]        features_r;
    logic                out_valid_r;
    logic                in_ready_r;
    logic                drop_r;
    logic signed [15:0]  inv_std_r  [0:7];
    logic signed [23:0]  mean_acc_r [0:7];

    logic [15:0]         raw_ch_s;
    logic [15:0]         mean_ch_s;
    logic [15:0]         mean_eff_s;
    logic signed [15:0]  inv_ch_s;
    logic signed [16:0]  d_s;
    logic signed [32:0]  p_s;
    logic signed [32:0]  z_wide_s;
    logic [15:0]         z_sat_s;
    logic [127:0]        stage_next_s;

`ifdef BOREAL_NORM_ADAPT_EN
    logic                primed_r;
    logic signed [24:0]  target_s;
    logic signed [24:0]  acc_ext_s;
    logic signed [24:0]  ema_s;
    logic [23:0]         mean_next_s;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.features  = features_r;
    assign bus.out_valid = out_valid_r;
    assign bus.drop      = drop_r;

    // Channel datapath: subtract mean, scale by inv_std, saturate to 16 bits.
    always_comb begin
        raw_ch_s  = raw_r[ch_r*16 +: 16];
        mean_ch_s = mean_acc_r[ch_r][23:8];
        inv_ch_s  = inv_std_r[ch_r];
`ifdef BOREAL_NORM_ADAPT_EN
        // Before the first sample the mean is seeded from raw, so z is forced to 0.
        if (primed_r) begin
            mean_eff_s = mean_ch_s;
        end else begin
            mean_eff_s = raw_ch_s;
        end
`else
        mean_eff_s = mean_ch_s;
`endif
        d_s      = {raw_ch_s[15], raw_ch_s} - {mean_eff_s[15], mean_eff_s};
        p_s      = d_s * inv_ch_s;
        z_wide_s = p_s >>> 5'd12;
        if (z_wide_s > 33'sd32767) begin
            z_sat_s = 16'h7FFF;
        end else if (z_wide_s < -33'sd32768) begin
            z_sat_s = 16'h8000;
        end else begin
            z_sat_s = z_wide_s[15:0];
        end
        stage_next_s = stage_r;
        stage_next_s[ch_r*16 +: 16] = z_sat_s;
    end

`ifdef BOREAL_NORM_ADAPT_EN
    // EMA step in 25-bit arithmetic; the first sample loads the mean directly.
    always_comb begin
        target_s  = {raw_ch_s[15], raw_ch_s, 8'h00};
        acc_ext_s = {mean_acc_r[ch_r][23], mean_acc_r[ch_r]};
        ema_s     = acc_ext_s + ((target_s - acc_ext_s) >>> ALPHA_SHIFT);
        if (primed_r) begin
            mean_next_s = ema_s[23:0];
        end else begin
            mean_next_s = target_s[23:0];
        end
    end
`endif

    // Coefficient and mean registers; a register write overrides the adaptive update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                inv_std_r[i]  <= 16'sh1000;
                mean_acc_r[i] <= 24'sh000000;
            end
        end else begin
`ifdef BOREAL_NORM_ADAPT_EN
            if (state_r == RUN) begin
                mean_acc_r[ch_r] <= mean_next_s;
            end
`endif
            if (bus.reg_we) begin
                if (!bus.reg_addr[3]) begin
                    inv_std_r[bus.reg_addr[2:0]] <= bus.reg_din;
                end else begin
                    mean_acc_r[bus.reg_addr[2:0]] <= {bus.reg_din, 8'h00};
                end
            end
        end
    end

    // Sequencer: accept in IDLE, walk channels 0..7 in RUN, publish after channel 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            ch_r        <= 3'd0;
            raw_r       <= 128'd0;
            stage_r     <= 128'd0;
            features_r  <= 128'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            drop_r      <= 1'b0;
`ifdef BOREAL_NORM_ADAPT_EN
            primed_r    <= 1'b0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            if (bus.valid && !in_ready_r) begin
                drop_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.valid) begin
                        raw_r      <= bus.raw;
                        ch_r       <= 3'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    stage_r <= stage_next_s;
                    if (ch_r == 3'd7) begin
                        features_r  <= stage_next_s;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
`ifdef BOREAL_NORM_ADAPT_EN
                        primed_r    <= 1'b1;
`endif
                    end else begin
                        ch_r <= ch_r + 3'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boreal_feature_normalizer.sv
// Self-checking bench for boreal_feature_normalizer: directed tables, corner
// sequences and randomized samples against an arithmetic reference model.
module tb_boreal_feature_normalizer;
    localparam int ALPHA = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    boreal_feature_normalizer_if bus ();
    boreal_feature_normalizer #(.ALPHA_SHIFT(ALPHA)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    // reference state: inverse std (integer Q4.12), mean accumulator (Q16.8 as integer)
    int m_inv [8];
    int m_acc [8];
    bit m_primed;

    typedef struct {
        logic [127:0] raw;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [3];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        logic [127:0] v;
        v = {a7[15:0], a6[15:0], a5[15:0], a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
        return v;
    endfunction

    task automatic model_reset;
        for (int c = 0; c < 8; c++) begin
            m_inv[c] = 4096;
            m_acc[c] = 0;
        end
        m_primed = 1'b0;
    endtask

    // z = floor((raw - mean) * inv / 4096), clipped to int16; adaptive mean follows the EMA rule
    function automatic logic [127:0] model(input logic [127:0] r);
        logic [127:0] o;
        for (int c = 0; c < 8; c++) begin
            int rv;
            int mv;
            longint z;
            logic [15:0] raw16;
            raw16 = r[c*16 +: 16];
            rv = int'($signed(raw16));
            mv = m_acc[c] >>> 8;
`ifdef BOREAL_NORM_ADAPT_EN
            if (!m_primed) mv = rv;
`endif
            z = (longint'(rv - mv) * longint'(m_inv[c])) >>> 12;
            if (z > 32767) z = 32767;
            if (z < -32768) z = -32768;
            o[c*16 +: 16] = z[15:0];
`ifdef BOREAL_NORM_ADAPT_EN
            if (!m_primed) m_acc[c] = rv * 256;
            else m_acc[c] = m_acc[c] + ((rv * 256 - m_acc[c]) >>> ALPHA);
`endif
        end
        m_primed = 1'b1;
        return o;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        bus.valid  = 1'b0;
        bus.reg_we = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [15:0] din);
        bus.reg_addr = addr;
        bus.reg_din  = din;
        bus.reg_we   = 1'b1;
        step();
        bus.reg_we = 1'b0;
        if (addr < 4'd8) m_inv[addr[2:0]] = int'($signed(din));
        else m_acc[addr[2:0]] = int'($signed(din)) * 256;
    endtask

    task automatic send(input logic [127:0] r);
        bus.raw   = r;
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
    endtask

    // counts edges after the accept edge until out_valid is seen; 0 means it never came
    task automatic wait_out(input int start, output int lat);
        lat = 0;
        for (int i = start + 1; i <= 30; i++) begin
            step();
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_sample(input string name, input logic [127:0] r, input logic [127:0] exp);
        int lat;
        send(r);
        wait_out(0, lat);
        check({name, "_latency"}, lat, 128'd8);
        check(name, bus.features, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        int t [$];
        logic [127:0] r;
        logic [127:0] e;

        bus.valid    = 1'b0;
        bus.raw      = 128'd0;
        bus.reg_addr = 4'd0;
        bus.reg_din  = 16'd0;
        bus.reg_we   = 1'b0;
        do_reset();

        check("reset_in_ready",  {127'd0, bus.in_ready},  128'd1);
        check("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check("reset_drop",      {127'd0, bus.drop},      128'd0);
        check("reset_features",  bus.features,            128'd0);

`ifndef BOREAL_NORM_ADAPT_EN
        run_sample("defaults_ch0", pack8(1000, 0, 0, 0, 0, 0, 0, 0), pack8(1000, 0, 0, 0, 0, 0, 0, 0));

        reg_write(4'd1, 16'h4000);
        reg_write(4'd2, 16'h0800);
        reg_write(4'd11, 16'd500);
        tbl[0].raw = pack8(1000, 20000, -300, 200, 0, 0, 0, 0);
        tbl[0].exp = pack8(1000, 32767, -150, -300, 0, 0, 0, 0);
        tbl[1].raw = pack8(-5, -20000, 301, -32768, 32767, -32768, 7, -1);
        tbl[1].exp = pack8(-5, -32768, 150, -32768, 32767, -32768, 7, -1);
        tbl[2].raw = pack8(0, 8191, -301, 32767, 100, -100, 0, 0);
        tbl[2].exp = pack8(0, 32764, -151, 32267, 100, -100, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run_sample($sformatf("table%0d", i), tbl[i].raw, tbl[i].exp);
        end

        // mean of ch0 changes after ch0 is done (ignored); mean of ch5 changes before ch5 (used)
        send(pack8(1000, 0, 0, 0, 0, 1000, 0, 0));
        step();
        bus.reg_addr = 4'd8;  bus.reg_din = 16'd400; bus.reg_we = 1'b1;
        step();
        bus.reg_addr = 4'd13; bus.reg_din = 16'd400;
        step();
        bus.reg_we = 1'b0;
        wait_out(3, lat);
        check("midrun_write_latency", lat, 128'd8);
        check("midrun_write", bus.features, pack8(1000, 0, 0, -500, 0, 600, 0, 0));
`else
        run_sample("adapt_prime", {8{16'd4096}}, 128'd0);
        run_sample("adapt_steady", {8{16'd4096}}, 128'd0);
        run_sample("adapt_step", {8{16'd8192}}, {8{16'd4096}});
        run_sample("adapt_decay", {8{16'd8192}}, {8{16'd4032}});
`endif

        check("drop_before_busy", {127'd0, bus.drop}, 128'd0);
        bus.raw   = pack8(1000, 0, 0, 0, 0, 0, 0, 0);
        bus.valid = 1'b1;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 20) bus.valid = 1'b0;
            step();
            if (bus.out_valid) begin
                pulses++;
                t.push_back(i);
            end
        end
        bus.valid = 1'b0;
        check("busy_pulses", pulses, 128'd3);
        check("busy_drop", {127'd0, bus.drop}, 128'd1);
        if (t.size() == 3) check("busy_spacing", t[2] - t[1], t[1] - t[0]);
        else check("busy_spacing_count", t.size(), 128'd3);

        // reset during the 4th RUN cycle
        send(pack8(111, 222, 333, 444, 555, 666, 777, 888));
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("midrst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        check("midrst_features",  bus.features,            128'd0);
        check("midrst_in_ready",  {127'd0, bus.in_ready},  128'd1);
        check("midrst_drop",      {127'd0, bus.drop},      128'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) pulses++;
        end
        check("midrst_no_output", pulses, 128'd0);
`ifndef BOREAL_NORM_ADAPT_EN
        run_sample("post_rst_defaults", pack8(0, 1000, 0, -7, 0, 0, 0, 0), pack8(0, 1000, 0, -7, 0, 0, 0, 0));
`endif

        do_reset();
        for (int n = 0; n < 20; n++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                reg_write(4'($urandom_range(0, 15)), 16'($urandom));
            end
            for (int c = 0; c < 8; c++) r[c*16 +: 16] = 16'($urandom);
            e = model(r);
            run_sample($sformatf("random%0d", n), r, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
